conv2d_stream: RTL and testbench

Streaming 2-D convolution engine: the parametrised successor to the flat-bus `top` convolver. Pixels arrive one per handshake in raster order. K−1 line buffers build a K×K window, and a pipelined signed MAC produces one output per valid window position (no padding). Results are shifted, saturated and streamed out with valid/ready backpressure. The coefficients are runtime-loadable and the frame size is set by parameters.

---
 rtl/conv_pkg.sv | 27 ++
 rtl/conv_line_buffer.sv | 39 +++
 rtl/conv2d_stream.sv | 165 ++++++++++++++++
 tb/tb_conv2d_stream.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming 2-D convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_e;

    // Accumulator width that holds a full K*K sum of products without overflow.
    function automatic int acc_w(input int data_w, input int coef_w, input int k);
        return data_w + coef_w + 1 + $clog2(k * k);
    endfunction

    // Clamp a sign-extended value into the signed range of an out_w-bit result.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int               out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 row delay lines plus the K x K window register; advances one pixel per enable.
module conv_line_buffer #(
    parameter int IMG_W  = 128,
    parameter int K      = 3,
    parameter int DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          en_i,
    input  logic [DATA_W-1:0]             pix_i,
    output logic [K*K-1:0][DATA_W-1:0]    win_o
);

    logic [DATA_W-1:0]          line_q [K-1][IMG_W];
    logic [DATA_W-1:0]          tap    [K];
    logic [K*K-1:0][DATA_W-1:0] win_q;

    // tap[j] is the pixel in the same column j rows above the incoming one.
    always_comb begin
        tap[0] = pix_i;
        for (int j = 1; j < K; j++) tap[j] = line_q[j-1][IMG_W-1];
    end

    // NOTE: storage has no reset; window validity comes from the counters in the top.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int j = 0; j < K - 1; j++) begin
                line_q[j][0] <= tap[j];
                for (int i = 1; i < IMG_W; i++) line_q[j][i] <= line_q[j][i-1];
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) win_q[r*K + c] <= win_q[r*K + c + 1];
                win_q[r*K + K - 1] <= tap[K-1-r];
            end
        end
    end

    assign win_o = win_q;

endmodule

// File: rtl/conv2d_stream.sv
// Streaming K x K convolution: counters, FSM, coefficient file and a 3-stage MAC pipeline.
module conv2d_stream
    import conv_pkg::*;
#(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int K      = 3,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         coef_we,
    input  logic [$clog2(K*K)-1:0]                       coef_addr,
    input  logic signed [COEF_W-1:0]                     coef_data,
    input  logic [$clog2(acc_w(DATA_W, COEF_W, K))-1:0]  shift,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [DATA_W-1:0]                            in_data,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic signed [OUT_W-1:0]                      out_data,
    output logic                                         out_sat,
    output logic                                         out_last,
    output logic                                         frame_done,
    output logic                                         busy
);

    localparam int NTAP   = K * K;
    localparam int ACC_W  = acc_w(DATA_W, COEF_W, K);
    localparam int PROD_W = DATA_W + COEF_W + 1;
    localparam int SH_W   = $clog2(ACC_W);
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);

    state_e                       state_q, state_d;
    logic [COL_W-1:0]             col_q;
    logic [ROW_W-1:0]             row_q;
    logic [SH_W-1:0]              shift_q;
    logic signed [COEF_W-1:0]     coef_q [NTAP];
    logic [NTAP-1:0][DATA_W-1:0]  win;
    logic signed [PROD_W-1:0]     prod_q [NTAP];
    logic                         v1_q, last1_q, v2_q, last2_q;
    logic                         out_valid_q, out_sat_q, out_last_q, frame_done_q;
    logic signed [OUT_W-1:0]      out_data_q;
    logic signed [ACC_W-1:0]      acc, acc_sh;
    logic signed [63:0]           clamped;
    logic                         stall, accept, last_pix, win_ok, out_hs;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !rst && (state_q != FLUSH) && !stall;
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;
    assign last_pix = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));
    assign win_ok   = (row_q >= ROW_W'(K - 1)) && (col_q >= COL_W'(K - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: default first so every path assigns state_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (accept && last_pix) state_d = FLUSH;
            FLUSH:   if (out_hs && out_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state always uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_q <= '0;
                row_q <= last_pix ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                            shift_q <= '0;
        else if (state_q == IDLE && accept) shift_q <= shift;
    end

    // Writes only land in IDLE, so a running frame sees a frozen coefficient set.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAP; i++) coef_q[i] <= '0;
        end else if (coef_we && state_q == IDLE && int'(coef_addr) < NTAP) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    conv_line_buffer #(
        .IMG_W  (IMG_W),
        .K      (K),
        .DATA_W (DATA_W)
    ) u_line_buffer (
        .clk   (clk),
        .en_i  (accept),
        .pix_i (in_data),
        .win_o (win)
    );

    always_ff @(posedge clk) begin
        if (!stall && v1_q) begin
            for (int i = 0; i < NTAP; i++)
                prod_q[i] <= PROD_W'($signed({1'b0, win[i]})) * PROD_W'(coef_q[i]);
        end
    end

    // NOTE: blocking assignments here build a combinational adder chain.
    always_comb begin
        acc = '0;
        for (int i = 0; i < NTAP; i++) acc = acc + ACC_W'(prod_q[i]);
        acc_sh  = acc >>> shift_q;
        clamped = saturate(64'(acc_sh), OUT_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            last1_q     <= 1'b0;
            v2_q        <= 1'b0;
            last2_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_sat_q   <= 1'b0;
            out_data_q  <= '0;
        end else if (!stall) begin
            v1_q        <= accept && win_ok;
            last1_q     <= accept && last_pix;
            v2_q        <= v1_q;
            last2_q     <= last1_q;
            out_valid_q <= v2_q;
            out_last_q  <= last2_q;
            if (v2_q) begin
                out_data_q <= clamped[OUT_W-1:0];
                out_sat_q  <= (clamped != 64'(acc_sh));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) frame_done_q <= 1'b0;
        else     frame_done_q <= out_hs && out_last_q;
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sat    = out_sat_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_conv2d_stream.sv
// Self-checking bench for conv2d_stream: 8x8 frames, K=3, a 16-bit and an 8-bit output instance.
module tb_conv2d_stream;

    localparam int W     = 8;
    localparam int H     = 8;
    localparam int K     = 3;
    localparam int DW    = 8;
    localparam int CW    = 8;
    localparam int NT    = K * K;
    localparam int OW_N  = W - K + 1;
    localparam int NOUT  = OW_N * (H - K + 1);
    localparam int AW    = $clog2(NT);
    localparam int ACC_W = DW + CW + 1 + $clog2(NT);
    localparam int SW    = $clog2(ACC_W);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, coef_we, in_valid, out_ready;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_data;
    logic [SW-1:0] shift;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid, out_sat, out_last, frame_done, busy;
    logic [15:0]   out_data;
    logic          in_ready8, out_valid8, out_sat8, out_last8, frame_done8, busy8;
    logic [7:0]    out_data8;

    conv2d_stream #(.IMG_W(W), .IMG_H(H), .K(K), .DATA_W(DW), .COEF_W(CW), .OUT_W(16)) dut (
        .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .shift(shift), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .out_last(out_last), .frame_done(frame_done), .busy(busy)
    );

    conv2d_stream #(.IMG_W(W), .IMG_H(H), .K(K), .DATA_W(DW), .COEF_W(CW), .OUT_W(8)) dut8 (
        .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .shift(shift), .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .out_sat(out_sat8),
        .out_last(out_last8), .frame_done(frame_done8), .busy(busy8)
    );

    typedef struct {
        int v16; bit s16; bit l16; int v8; bit s8;
    } got_t;

    typedef struct {
        string name;
        int    img_kind;   // 0 ramp, 1 all 255, 2 random
        int    coef_kind;  // 0 keep, 1 ones, 2 laplacian, 3 all 127, 4 all -128, 5 random
        int    sh;         // -1 picks a random shift
        int    pv;
        int    pr;
        int    mid;
        bit    fwe;
        int    fwv;
        bit    fixed;
        int    e_first;
        int    e_last;
        int    e8_first;
        bit    e_sat;
    } vec_t;

    int   n_checks = 0, n_fail = 0;
    int   img [W*H];
    int   coef_m [NT];
    got_t got [$];
    int   out_at [$];
    int   acc_at [W*H];
    int   cyc = 0, pix_idx = 0, pv = 100, pr = 100, mid_we = -1, fw_val = 0;
    int   fd_seen = 0, spurious_fd = 0, lockstep_err = 0, frame_shift = 0;
    bit   streaming = 0, first_we = 0, last_hs = 0, prev_stall = 0;
    logic [15:0] p_data;
    logic        p_sat, p_last;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Direct evaluation of one output position from the image, coefficients and frame shift.
    function automatic longint ref_val(input int r, input int c, input int ow, output bit sat);
        longint acc, hi, lo;
        acc = 0;
        for (int dr = 0; dr < K; dr++)
            for (int dc = 0; dc < K; dc++)
                acc += longint'(img[(r - K + 1 + dr) * W + (c - K + 1 + dc)]) * coef_m[dr * K + dc];
        acc = acc >>> frame_shift;
        hi  = (longint'(1) << (ow - 1)) - 1;
        lo  = -(longint'(1) << (ow - 1));
        sat = 1'b0;
        if (acc > hi) begin sat = 1'b1; return hi; end
        if (acc < lo) begin sat = 1'b1; return lo; end
        return acc;
    endfunction

    task automatic step();
        @(negedge clk);
        if (last_hs) begin
            check("frame_done pulse", frame_done, 1);
            check("busy after last", busy, 0);
            fd_seen++;
        end else if (frame_done) begin
            spurious_fd++;
        end
        if (prev_stall) begin
            check("stall hold valid", out_valid, 1);
            check("stall hold data", out_data, p_data);
            check("stall hold sat", out_sat, p_sat);
            check("stall hold last", out_last, p_last);
        end
        coef_we   = 1'b0;
        out_ready = (int'($urandom_range(99)) < pr);
        in_valid  = 1'b0;
        if (streaming && pix_idx < W * H) begin
            in_valid = (int'($urandom_range(99)) < pv);
            in_data  = DW'(img[pix_idx]);
            if (pix_idx > 0) shift = SW'($urandom_range(ACC_W - 1));
            if (pix_idx == 0 && first_we) begin
                in_valid  = 1'b1;
                coef_we   = 1'b1;
                coef_addr = '0;
                coef_data = CW'(fw_val);
            end
            if (pix_idx == mid_we) begin
                coef_we   = 1'b1;
                coef_addr = AW'(4);
                coef_data = CW'(5);
            end
        end
        #1;
        last_hs = 1'b0;
        if (in_valid && in_ready) begin
            acc_at[pix_idx] = cyc;
            pix_idx++;
        end
        if (out_valid && out_ready) begin
            got.push_back('{int'($signed(out_data)), out_sat, out_last, int'($signed(out_data8)), out_sat8});
            out_at.push_back(cyc);
            last_hs = out_last;
        end
        if (in_ready8 !== in_ready || out_valid8 !== out_valid || out_last8 !== out_last ||
            busy8 !== busy || frame_done8 !== frame_done) lockstep_err++;
        prev_stall = out_valid && !out_ready;
        p_data = out_data;
        p_sat  = out_sat;
        p_last = out_last;
        cyc++;
    endtask

    task automatic run_frame(input string tag, input int pvv, input int prr, input int mid,
                             input bit fwe, input int fwv);
        int  r, c;
        bit  s16, s8;
        longint e16, e8;
        got.delete();
        out_at.delete();
        pix_idx = 0; pv = pvv; pr = prr; mid_we = mid; first_we = fwe; fw_val = fwv;
        frame_shift = int'(shift);
        if (fwe) coef_m[0] = fwv;
        fd_seen = 0;
        streaming = 1'b1;
        for (int n = 0; n < 4000 && fd_seen == 0; n++) step();
        streaming = 1'b0; first_we = 1'b0; mid_we = -1;
        check({tag, " frame_done seen"}, fd_seen, 1);
        check({tag, " count"}, got.size(), NOUT);
        for (int i = 0; i < got.size() && i < NOUT; i++) begin
            r   = K - 1 + i / OW_N;
            c   = K - 1 + i % OW_N;
            e16 = ref_val(r, c, 16, s16);
            e8  = ref_val(r, c, 8, s8);
            check($sformatf("%s data[%0d]", tag, i), got[i].v16, e16);
            check($sformatf("%s sat[%0d]", tag, i), got[i].s16, s16);
            check($sformatf("%s last[%0d]", tag, i), got[i].l16, (i == NOUT - 1) ? 1 : 0);
            check($sformatf("%s data8[%0d]", tag, i), got[i].v8, e8);
            check($sformatf("%s sat8[%0d]", tag, i), got[i].s8, s8);
        end
        if (pvv == 100 && prr == 100 && out_at.size() > 0)
            check({tag, " latency"}, out_at[0] - acc_at[(K - 1) * W + K - 1], 3);
    endtask

    task automatic set_image(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0:       img[r * W + c] = W * r + c + 1;
                    1:       img[r * W + c] = 255;
                    default: img[r * W + c] = int'($urandom_range(255));
                endcase
    endtask

    task automatic load_coefs(input int kind);
        int v;
        if (kind == 0) return;
        for (int i = 0; i < NT; i++) begin
            @(negedge clk);
            case (kind)
                1:       v = 1;
                2:       v = (i == NT / 2) ? 8 : -1;
                3:       v = 127;
                4:       v = -128;
                default: v = int'($urandom_range(255)) - 128;
            endcase
            coef_we   = 1'b1;
            coef_addr = AW'(i);
            coef_data = CW'(v);
            coef_m[i] = v;
        end
        @(negedge clk);
        coef_addr = AW'(NT);
        coef_data = CW'(77);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    vec_t vecs [12];
    int   quiet_err;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; shift = '0;
        for (int i = 0; i < NT; i++) coef_m[i] = 0;

        vecs[0]  = '{"zero_coefs",  0, 0,  0, 100, 100, -1, 0,  0, 1,      0,      0,    0, 0};
        vecs[1]  = '{"ones",        0, 1,  0, 100, 100, -1, 0,  0, 1,     90,    495,   90, 0};
        vecs[2]  = '{"ones_shift2", 0, 0,  2, 100, 100, -1, 0,  0, 1,     22,    123,   22, 0};
        vecs[3]  = '{"laplacian",   0, 2,  0, 100, 100, -1, 0,  0, 1,      0,      0,    0, 0};
        vecs[4]  = '{"sat_pos",     1, 3,  0, 100, 100, -1, 0,  0, 1,  32767,  32767,  127, 1};
        vecs[5]  = '{"sat_neg",     1, 4,  0, 100, 100, -1, 0,  0, 1, -32768, -32768, -128, 1};
        vecs[6]  = '{"ones_stall",  0, 1,  0,  70,  50, -1, 0,  0, 1,     90,    495,   90, 0};
        vecs[7]  = '{"random_a",    2, 5, -1,  60,  50, -1, 0,  0, 0,      0,      0,    0, 0};
        vecs[8]  = '{"mid_write",   0, 1,  0, 100, 100, 30, 0,  0, 1,     90,    495,   90, 0};
        vecs[9]  = '{"after_mid",   0, 0,  0, 100, 100, -1, 0,  0, 1,     90,    495,   90, 0};
        vecs[10] = '{"first_write", 0, 1,  0, 100, 100, -1, 1, 10, 1,     99,    909,   99, 0};
        vecs[11] = '{"random_b",    2, 5, -1,  80,  40, -1, 0,  0, 0,      0,      0,    0, 0};

        repeat (3) @(negedge clk);
        #1;
        check("reset in_ready", in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_sat", out_sat, 0);
        check("reset out_last", out_last, 0);
        check("reset frame_done", frame_done, 0);
        check("reset busy", busy, 0);
        rst = 1'b0;
        #1;
        check("idle in_ready", in_ready, 1);

        for (int v = 0; v < 12; v++) begin
            set_image(vecs[v].img_kind);
            load_coefs(vecs[v].coef_kind);
            @(negedge clk);
            shift = (vecs[v].sh < 0) ? SW'($urandom_range(6)) : SW'(vecs[v].sh);
            run_frame(vecs[v].name, vecs[v].pv, vecs[v].pr, vecs[v].mid, vecs[v].fwe, vecs[v].fwv);
            if (vecs[v].fixed && got.size() > 0) begin
                check({vecs[v].name, " first"}, got[0].v16, vecs[v].e_first);
                check({vecs[v].name, " last"}, got[got.size() - 1].v16, vecs[v].e_last);
                check({vecs[v].name, " first8"}, got[0].v8, vecs[v].e8_first);
                check({vecs[v].name, " first sat"}, got[0].s16, vecs[v].e_sat);
                check({vecs[v].name, " last flag"}, got[got.size() - 1].l16, 1);
            end
        end

        // Abandon a frame after 20 pixels, then run a clean one.
        set_image(0);
        @(negedge clk);
        shift = '0;
        pix_idx = 0; pv = 100; pr = 100; streaming = 1'b1;
        for (int n = 0; n < 200 && pix_idx < 20; n++) step();
        streaming = 1'b0;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_hs = 1'b0; prev_stall = 1'b0;
        for (int i = 0; i < NT; i++) coef_m[i] = 0;
        quiet_err = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            #1;
            if (out_valid || frame_done || busy) quiet_err++;
        end
        check("abort quiet", quiet_err, 0);
        load_coefs(1);
        @(negedge clk);
        shift = '0;
        run_frame("after_abort", 100, 100, -1, 1'b0, 0);
        if (got.size() > 0) begin
            check("after_abort first", got[0].v16, 90);
            check("after_abort last", got[got.size() - 1].v16, 495);
        end

        check("spurious frame_done", spurious_fd, 0);
        check("wide/narrow lockstep", lockstep_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
